regbank_ctrl: RTL
=================

# regbank_ctrl

Command-driven initiator for the 4×4-bit register bank.
- Accepts a nibble-wide command stream over a valid/ready handshake and decodes it.
- Drives the bank's write port: data plus one-hot load strobes.
- Drives the bank's read select, captures the read-back nibble, and returns it on a valid/ready response channel.
- Sits between the external nibble interface and the register bank, which stays purely storage-plus-mux.

## Interface
Parameters:
- CLEAR_VAL, 4'h0, nibble written to every register by the CLEAR command

Ports:
- ck  in  1  clock, all flops on rising edge
- res  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_data  in  4  command/data nibble
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  block accepts cmd_data this cycle
- rf_d  out  4  write data to bank (registered)
- rf_load  out  4  one-hot load strobes, bit n loads register n (registered)
- rf_sel  out  2  read select to bank (registered)
- rf_q  in  4  bank read data for rf_sel (combinational in bank)
- rsp_data  out  4  read result
- rsp_valid  out  1  rsp_data valid, held until accepted
- rsp_ready  in  1  consumer accepts response
- err  out  1  one-cycle pulse on illegal opcode
- busy  out  1  high whenever state is not IDLE

## Operation
- Opcodes, first nibble in IDLE:
  - 00nn WRITE reg nn: next accepted nibble is the data.
  - 01nn READ reg nn.
  - 1000 CLEAR all registers.
  - 1001 SCAN, only when configured in.
  - All other opcodes are illegal.
- States and transitions:
  - IDLE: cmd_ready=1. WRITE→WDATA, READ→RSEL, CLEAR→CLR, SCAN→RSEL with scan flag set, illegal→IDLE with err pulse.
  - WDATA: cmd_ready=1. Waits indefinitely for the data nibble, then →WR.
  - WR: rf_load=onehot(nn), rf_d=data for exactly one cycle, →IDLE.
  - RSEL: rf_sel=index; rf_q is sampled into rsp_data at the end of the cycle, →RSP.
  - RSP: rsp_valid=1 until rsp_valid&rsp_ready. On handshake: →IDLE, or in SCAN with index<3, index+1 and →RSEL.
  - CLR: 2-bit counter 0..3, rf_load=onehot(cnt), rf_d=CLEAR_VAL each cycle, →IDLE after cnt=3.
- Outputs between operations:
  - rf_load is 0 outside WR/CLR.
  - rf_d, rf_sel and rsp_data hold their last value.
- Flow control and errors:
  - cmd_ready=0 in WR, RSEL, RSP, CLR; cmd_valid is ignored there.
  - err never changes state and never touches the bank.
- Reset values: state IDLE, cmd_ready=1, rf_d=0, rf_load=0, rf_sel=0, rsp_data=0, rsp_valid=0, err=0, busy=0.
- Reset mid-operation: all outputs take reset values immediately; a partial CLEAR or SCAN is abandoned; no load strobe occurs after reset deasserts.

## Timing
- WRITE:
  - Opcode accepted cycle N, data accepted cycle M>N.
  - rf_load/rf_d valid cycle M+1.
  - cmd_ready high again cycle M+2.
- READ:
  - Opcode accepted cycle N.
  - rf_sel valid cycle N+1.
  - rsp_valid rises cycle N+2.
  - If rsp_ready is already high, the handshake completes in N+2 and cmd_ready is high in N+3.
- CLEAR: accepted N; loads 0001, 0010, 0100, 1000 in cycles N+1..N+4; idle at N+5.
- SCAN: four responses in order reg0..reg3; each RSEL/RSP pair takes at least 2 cycles.
- Illegal opcode: accepted N; err=1 in cycle N+1 only; cmd_ready stays high.
- busy=1 from the cycle after opcode acceptance until return to IDLE.

## Configuration
- REGBANK_CTRL_SCAN_EN defined: opcode 1001 performs SCAN as above.
- Not defined:
  - 1001 is illegal (err pulse).
  - The scan flag and index-increment logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package regbank_pkg holds:
  - opcode constants: OP_WRITE=2'b00 prefix, OP_READ=2'b01 prefix, OP_CLEAR=4'b1000, OP_SCAN=4'b1001
  - state encoding: IDLE, WDATA, WR, RSEL, RSP, CLR
  - NREG=4
- One sub-module is natural: regbank_rsp_buf, the response holding register with the valid/ready hold logic.
- Decode and FSM stay in regbank_ctrl.

## Test plan
- Reset, then WRITE: opcode 4'h2, then data 4'hA. rf_load=4'b0100 and rf_d=4'hA for exactly one cycle; rf_load=0 otherwise.
- READ: opcode 4'h6 with the bank model returning 4'hA for sel=2. rf_sel=2 at N+1; rsp_data=4'hA, rsp_valid from N+2. Hold rsp_ready low for 3 cycles: rsp_valid stays high and cmd_ready stays low.
- CLEAR: opcode 4'h8 with CLEAR_VAL=4'h0. Loads 1, 2, 4, 8 on consecutive cycles; every register reads 0 afterwards.
- SCAN with macro defined, bank holding 3, 7, B, F: responses 3, 7, B, F in order. Without the macro, 4'h9 gives an err pulse and no rf_load activity.
- Illegal opcode 4'hC gives a one-cycle err pulse and busy stays 0. Asserting res during CLEAR cycle N+2 clears all outputs immediately, and no further rf_load follows.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank command controller.
//   NREG/DW/IW : register count, data width, register index width
//   OP_*       : command opcodes (2-bit prefixes for WRITE/READ, full nibbles otherwise)
//   state_e    : controller state encoding
//   cmd_t      : first-nibble layout (opcode prefix + register index)
//   onehot()   : register index to load-strobe vector
package regbank_pkg;

    localparam int unsigned NREG = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned IW   = 2;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [3:0] OP_CLEAR = 4'b1000;
    localparam logic [3:0] OP_SCAN  = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WR,
        RSEL,
        RSP,
        CLR
    } state_e;

    typedef struct packed {
        logic [1:0]    op;
        logic [IW-1:0] idx;
    } cmd_t;

    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        return NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/regbank_rsp_buf.sv
// Response holding register: captures the bank read-back nibble and holds
// it with valid asserted until the consumer accepts it.
//   ck, res    : clock, asynchronous active-low reset
//   cap        : load cap_data and raise valid at the end of this cycle
//   cap_data   : nibble to capture
//   rsp_ready  : consumer accepts the response
//   rsp_data   : held response nibble (registered)
//   rsp_valid  : response valid (registered)
//   rsp_hs_c   : handshake completes this cycle (combinational)
module regbank_rsp_buf
    import regbank_pkg::*;
(
    input  logic          ck,
    input  logic          res,
    input  logic          cap,
    input  logic [DW-1:0] cap_data,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_valid,
    output logic          rsp_hs_c
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // Capture has priority; capture and handshake never coincide in the controller.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (cap) begin
            data_d  = cap_data;
            valid_d = 1'b1;
        end else if (valid_q && rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rsp_data  = data_q;
    assign rsp_valid = valid_q;
    assign rsp_hs_c  = valid_q & rsp_ready;

endmodule

// File: rtl/regbank_ctrl.sv
// Command-driven initiator for the 4x4-bit register bank. Decodes a nibble
// command stream (WRITE/READ/CLEAR, optional SCAN), drives the bank write
// port and read select, and returns read data on a valid/ready channel.
// Optional feature: define REGBANK_CTRL_SCAN_EN to enable opcode 1001 (SCAN);
// otherwise 1001 is treated as an illegal opcode.
//   ck, res    : clock, asynchronous active-low reset
//   cmd_*      : command nibble stream (valid/ready)
//   rf_d       : bank write data (registered)
//   rf_load    : one-hot bank load strobes (registered)
//   rf_sel     : bank read select (registered)
//   rf_q       : bank read data for rf_sel
//   rsp_*      : read response channel (valid/ready, registered)
//   err        : one-cycle pulse on illegal opcode
//   busy       : high whenever the controller is not idle
module regbank_ctrl
    import regbank_pkg::*;
#(
    parameter logic [DW-1:0] CLEAR_VAL = 4'h0
) (
    input  logic            ck,
    input  logic            res,
    input  logic [DW-1:0]   cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic [DW-1:0]   rf_d,
    output logic [NREG-1:0] rf_load,
    output logic [IW-1:0]   rf_sel,
    input  logic [DW-1:0]   rf_q,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            err,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [DW-1:0]   rf_d_q, rf_d_d;
    logic [NREG-1:0] rf_load_q, rf_load_d;
    logic [IW-1:0]   rf_sel_q, rf_sel_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
`ifdef REGBANK_CTRL_SCAN_EN
    logic            scan_q, scan_d;
`endif

    logic            cmd_accept_c;
    logic            rsp_cap_c;
    logic            rsp_hs_c;
    cmd_t            cmd_c;

    assign cmd_accept_c = cmd_valid & cmd_ready_q;
    assign cmd_c        = cmd_t'(cmd_data);
    assign rsp_cap_c    = (state_q == RSEL);

    // Next-state decode, then registered outputs derived from the next state
    // so every strobe lines up with the state it belongs to.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rf_d_d  = rf_d_q;
        err_d   = 1'b0;
`ifdef REGBANK_CTRL_SCAN_EN
        scan_d  = scan_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_accept_c) begin
                    if (cmd_c.op == OP_WRITE) begin
                        idx_d   = cmd_c.idx;
                        state_d = WDATA;
                    end else if (cmd_c.op == OP_READ) begin
                        idx_d   = cmd_c.idx;
                        state_d = RSEL;
                    end else if (cmd_data == OP_CLEAR) begin
                        cnt_d   = '0;
                        state_d = CLR;
`ifdef REGBANK_CTRL_SCAN_EN
                    end else if (cmd_data == OP_SCAN) begin
                        idx_d   = '0;
                        scan_d  = 1'b1;
                        state_d = RSEL;
`endif
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (cmd_accept_c) begin
                    rf_d_d  = cmd_data;
                    state_d = WR;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RSEL: begin
                state_d = RSP;
            end
            RSP: begin
                if (rsp_hs_c) begin
`ifdef REGBANK_CTRL_SCAN_EN
                    if (scan_q && (idx_q != IW'(NREG - 1))) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = RSEL;
                    end else begin
                        scan_d  = 1'b0;
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            CLR: begin
                if (cnt_q == IW'(NREG - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rf_load_d = '0;
        rf_sel_d  = rf_sel_q;
        if (state_d == WR) begin
            rf_load_d = onehot(idx_d);
        end
        if (state_d == CLR) begin
            rf_load_d = onehot(cnt_d);
            rf_d_d    = CLEAR_VAL;
        end
        if (state_d == RSEL) begin
            rf_sel_d = idx_d;
        end
        cmd_ready_d = (state_d == IDLE) || (state_d == WDATA);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rf_d_q      <= '0;
            rf_load_q   <= '0;
            rf_sel_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rf_d_q      <= rf_d_d;
            rf_load_q   <= rf_load_d;
            rf_sel_q    <= rf_sel_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef REGBANK_CTRL_SCAN_EN
    // Scan flag: selects index-increment on response handshake.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            scan_q <= 1'b0;
        end else begin
            scan_q <= scan_d;
        end
    end
`endif

    // Read-back capture at the end of RSEL; held until accepted.
    regbank_rsp_buf u_rsp_buf (
        .ck        (ck),
        .res       (res),
        .cap       (rsp_cap_c),
        .cap_data  (rf_q),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_hs_c  (rsp_hs_c)
    );

    assign cmd_ready = cmd_ready_q;
    assign rf_d      = rf_d_q;
    assign rf_load   = rf_load_q;
    assign rf_sel    = rf_sel_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule
